// File: rtl/lsu_pkg.sv
// Shared types and widths for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_ADDR_BUS = 32;
  localparam int unsigned BE_W         = REG_BUS / 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  // Byte enables for an access; lanes shifted past bit 3 are dropped. Size 11 acts as word.
  function automatic logic [BE_W-1:0] size_to_be(input logic [1:0] size, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (size)
      SIZE_B:  be = BE_W'(4'b0001 << off);
      SIZE_H:  be = BE_W'(4'b0011 << off);
      default: be = BE_W'(4'b1111);
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data lane select and sign/zero extension toward the writeback stage.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [REG_BUS-1:0] i_rdata,
  input  logic [1:0]         i_offset,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  output logic [REG_BUS-1:0] o_data
);

  logic [REG_BUS-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SIZE_B: o_data = i_unsigned ? {{(REG_BUS-8){1'b0}}, w_shifted[7:0]}
                                  : {{(REG_BUS-8){w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H: o_data = i_unsigned ? {{(REG_BUS-16){1'b0}}, w_shifted[15:0]}
                                  : {{(REG_BUS-16){w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Data-memory load/store unit: req/gnt/rvalid bus access with pipeline stall.
// Define LSU_ALIGN_CHECK_EN to suppress misaligned half/word accesses and flag them.
module dm_lsu
  import lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_re,
  input  logic                    mem_we,
  input  logic [1:0]              mem_size,
  input  logic                    mem_unsigned,
  input  logic [REG_ADDR_BUS-1:0] addr,
  input  logic [REG_BUS-1:0]      wdata,
  output logic                    stall,
  output logic [REG_BUS-1:0]      ld_data,
  output logic                    ld_valid,
  output logic                    fault_bus,
  output logic                    fault_misaligned,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_ADDR_BUS-1:0] dbus_addr,
  output logic [BE_W-1:0]         dbus_be,
  output logic [REG_BUS-1:0]      dbus_wdata,
  input  logic                    dbus_gnt,
  input  logic                    dbus_rvalid,
  input  logic [REG_BUS-1:0]      dbus_rdata,
  input  logic                    dbus_err
);

  lsu_state_t r_state;
  lsu_state_t w_state_nxt;

  logic                    w_access;
  logic                    w_issue;
  logic [REG_BUS-1:0]      w_wdata_rep;
  logic [REG_BUS-1:0]      w_ld_ext;

  logic                    r_req;
  logic                    r_we;
  logic [REG_ADDR_BUS-1:0] r_addr;
  logic [1:0]              r_offset;
  logic [BE_W-1:0]         r_be;
  logic [REG_BUS-1:0]      r_wdata;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [REG_BUS-1:0]      r_ld_data;
  logic                    r_ld_valid;
  logic                    r_fault_bus;

  assign w_access = mem_re | mem_we;

`ifdef LSU_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_fault_mis;

  // Size 11 is a word, so mem_size[1] covers both word encodings.
  assign w_misaligned = ((mem_size == SIZE_H) && addr[0]) ||
                        (mem_size[1] && (addr[1:0] != 2'b00));
  assign w_issue          = w_access && !w_misaligned;
  assign fault_misaligned = r_fault_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fault_mis <= 1'b0;
    else       r_fault_mis <= (r_state == LSU_IDLE) && w_access && w_misaligned;
  end
`else
  assign w_issue          = w_access;
  assign fault_misaligned = 1'b0;
`endif

  // Store data replicated onto every lane the enables may select.
  always_comb begin
    w_wdata_rep = wdata;
    case (mem_size)
      SIZE_B:  w_wdata_rep = {4{wdata[7:0]}};
      SIZE_H:  w_wdata_rep = {2{wdata[15:0]}};
      default: w_wdata_rep = wdata;
    endcase
  end

  lsu_load_extend u_load_extend (
    .i_rdata    (dbus_rdata),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LSU_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Stall covers detect, request and response cycles; DONE lets the pipeline advance.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_issue) begin
          stall       = 1'b1;
          w_state_nxt = LSU_REQ;
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (dbus_gnt) w_state_nxt = LSU_WAIT;
      end
      LSU_WAIT: begin
        stall = 1'b1;
        if (dbus_rvalid) w_state_nxt = LSU_DONE;
      end
      LSU_DONE: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_offset    <= 2'b00;
      r_be        <= '0;
      r_wdata     <= '0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_ld_data   <= '0;
      r_ld_valid  <= 1'b0;
      r_fault_bus <= 1'b0;
    end else begin
      r_ld_valid  <= 1'b0;
      r_fault_bus <= 1'b0;
      if ((r_state == LSU_IDLE) && w_issue) begin
        r_req      <= 1'b1;
        r_we       <= mem_we;
        r_addr     <= {addr[REG_ADDR_BUS-1:2], 2'b00};
        r_offset   <= addr[1:0];
        r_be       <= size_to_be(mem_size, addr[1:0]);
        r_wdata    <= w_wdata_rep;
        r_size     <= mem_size;
        r_unsigned <= mem_unsigned;
      end
      if ((r_state == LSU_REQ) && dbus_gnt) r_req <= 1'b0;
      if ((r_state == LSU_WAIT) && dbus_rvalid) begin
        if (dbus_err) begin
          r_fault_bus <= 1'b1;
        end else if (!r_we) begin
          r_ld_data  <= w_ld_ext;
          r_ld_valid <= 1'b1;
        end
      end
    end
  end

  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_be    = r_be;
  assign dbus_wdata = r_wdata;
  assign ld_data    = r_ld_data;
  assign ld_valid   = r_ld_valid;
  assign fault_bus  = r_fault_bus;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: bus responder with programmable gnt/rvalid latency.
module tb_dm_lsu;

  logic        clk;
  logic        reset;
  logic        mem_re, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, fault_bus, fault_misaligned;
  logic [31:0] ld_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid, dbus_err;

  int n_total;
  int n_bad;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          stall_cyc;
    int          vld;
    int          fb;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];

  int          obs_stall, obs_vld, obs_fb, obs_fm;
  logic        obs_issued, obs_unstable, obs_we;
  logic [31:0] obs_addr, obs_wd, obs_ld;
  logic [3:0]  obs_be;
  logic [31:0] model_ld;

  dm_lsu dut (
    .clk(clk), .reset(reset),
    .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .fault_bus(fault_bus), .fault_misaligned(fault_misaligned),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .dbus_err(dbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one access and plays the bus slave; records what the DUT did.
  task automatic do_access(input logic re, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                           input logic err, input logic exp_issue);
    int ph, cnt;
    bit fin;
    ph = 0; cnt = 0; fin = 0;
    obs_stall = 0; obs_vld = 0; obs_fb = 0; obs_fm = 0;
    obs_issued = 0; obs_unstable = 0; obs_ld = ld_data;
    @(negedge clk);
    mem_re = re; mem_we = we; mem_size = size; mem_unsigned = uns; addr = a; wdata = wd;
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      if (stall) obs_stall++;
      if (ld_valid) obs_vld++;
      if (fault_bus) obs_fb++;
      if (fault_misaligned) obs_fm++;
      dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0;
      if (ph == 3) begin
        fin = 1; obs_ld = ld_data; mem_re = 0; mem_we = 0;
      end else if (ph == 2) begin
        if (cnt == rv_dly) begin
          dbus_rvalid = 1; dbus_rdata = rd; dbus_err = err; ph = 3;
        end else cnt++;
      end else if (dbus_req) begin
        if (ph == 0) begin
          ph = 1; cnt = 0; obs_issued = 1;
          obs_addr = dbus_addr; obs_be = dbus_be; obs_wd = dbus_wdata; obs_we = dbus_we;
        end else if (dbus_addr !== obs_addr || dbus_be !== obs_be ||
                     dbus_wdata !== obs_wd || dbus_we !== obs_we) begin
          obs_unstable = 1;
        end
        if (cnt == gnt_dly) begin
          dbus_gnt = 1; ph = 2; cnt = 0;
        end else cnt++;
      end
      if (!exp_issue && c == 0) begin mem_re = 0; mem_we = 0; end
      if (!exp_issue && c == 3) fin = 1;
      if (!fin) @(negedge clk);
    end
    if (exp_issue) begin
      n_total++;
      if (!fin) begin n_bad++; $display("FAIL access_timeout addr=%h got no completion", a); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({stall, ld_valid, fault_bus, fault_misaligned, dbus_req, dbus_we} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b want=000000",
                        {stall, ld_valid, fault_bus, fault_misaligned, dbus_req, dbus_we});
    end
    n_total++;
    if (dbus_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", dbus_addr); end
    n_total++;
    if (dbus_be !== 4'h0) begin n_bad++; $display("FAIL reset_be got=%h want=0", dbus_be); end
    n_total++;
    if (dbus_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got=%h want=0", dbus_wdata); end
    n_total++;
    if (ld_data !== 32'h0) begin n_bad++; $display("FAIL reset_ld got=%h want=0", ld_data); end
    reset = 0;
    model_ld = 32'h0;
  endtask

  task automatic test_loads();
    logic [1:0]  tsz [8];
    logic        tun [8];
    logic [31:0] ta [8], trd [8], tex [8];
    logic [3:0]  tbe [8];
    exp_t e;
    tsz = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    tun = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ta  = '{32'h100, 32'h203, 32'h203, 32'h201, 32'h202, 32'h202, 32'h200, 32'h10C};
    trd = '{32'hDEADBEEF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h12347F56,
            32'h80011234, 32'h80011234, 32'h1234F00D, 32'h0BADF00D};
    tex = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h0000007F,
            32'hFFFF8001, 32'h00008001, 32'hFFFFF00D, 32'h0BADF00D};
    tbe = '{4'hF, 4'h8, 4'h8, 4'h2, 4'hC, 4'hC, 4'h3, 4'hF};
    for (int i = 0; i < 8; i++) begin
      e.addr = ta[i] & 32'hFFFF_FFFC; e.be = tbe[i]; e.wdata = 32'h0; e.we = 0;
      e.stall_cyc = 3 + (i % 3) + (i / 3); e.vld = 1; e.fb = 0; e.ld = tex[i];
      sb.push_back(e);
      do_access(1, 0, tsz[i], tun[i], ta[i], 32'h0, i % 3, i / 3, trd[i], 0, 1);
      e = sb.pop_front();
      n_total++;
      if (obs_addr !== e.addr || obs_we !== e.we) begin
        n_bad++; $display("FAIL ld_addr[%0d] got=%h/%b want=%h/%b", i, obs_addr, obs_we, e.addr, e.we);
      end
      n_total++;
      if (obs_be !== e.be) begin n_bad++; $display("FAIL ld_be[%0d] got=%h want=%h", i, obs_be, e.be); end
      n_total++;
      if (obs_stall !== e.stall_cyc) begin
        n_bad++; $display("FAIL ld_stall[%0d] got=%0d want=%0d", i, obs_stall, e.stall_cyc);
      end
      n_total++;
      if (obs_vld !== e.vld || obs_fb !== e.fb) begin
        n_bad++; $display("FAIL ld_valid[%0d] got=%0d/%0d want=%0d/%0d", i, obs_vld, obs_fb, e.vld, e.fb);
      end
      n_total++;
      if (obs_ld !== e.ld) begin n_bad++; $display("FAIL ld_data[%0d] got=%h want=%h", i, obs_ld, e.ld); end
      model_ld = e.ld;
    end
  endtask

  task automatic test_stores();
    logic [1:0]  tsz [3];
    logic [31:0] ta [3], twd [3], tew [3];
    logic [3:0]  tbe [3];
    int          tg [3], tr [3];
    exp_t e;
    tsz = '{2'd1, 2'd0, 2'd2};
    ta  = '{32'h302, 32'h101, 32'h104};
    twd = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D};
    tew = '{32'hABCDABCD, 32'h78787878, 32'hCAFEF00D};
    tbe = '{4'hC, 4'h2, 4'hF};
    tg  = '{2, 0, 1};
    tr  = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      e.addr = ta[i] & 32'hFFFF_FFFC; e.be = tbe[i]; e.wdata = tew[i]; e.we = 1;
      e.stall_cyc = 3 + tg[i] + tr[i]; e.vld = 0; e.fb = 0; e.ld = model_ld;
      sb.push_back(e);
      do_access(0, 1, tsz[i], 0, ta[i], twd[i], tg[i], tr[i], 32'hFFFFFFFF, 0, 1);
      e = sb.pop_front();
      n_total++;
      if (obs_addr !== e.addr || obs_we !== e.we || obs_be !== e.be) begin
        n_bad++; $display("FAIL st_addr_be[%0d] got=%h/%b/%h want=%h/%b/%h",
                          i, obs_addr, obs_we, obs_be, e.addr, e.we, e.be);
      end
      n_total++;
      if (obs_wd !== e.wdata) begin n_bad++; $display("FAIL st_wdata[%0d] got=%h want=%h", i, obs_wd, e.wdata); end
      n_total++;
      if (obs_unstable !== 1'b0) begin n_bad++; $display("FAIL st_stable[%0d] got=%b want=0", i, obs_unstable); end
      n_total++;
      if (obs_stall !== e.stall_cyc) begin
        n_bad++; $display("FAIL st_stall[%0d] got=%0d want=%0d", i, obs_stall, e.stall_cyc);
      end
      n_total++;
      if (obs_vld !== 0 || obs_ld !== e.ld) begin
        n_bad++; $display("FAIL st_ld[%0d] got=%0d/%h want=0/%h", i, obs_vld, obs_ld, e.ld);
      end
    end
  endtask

  task automatic test_bus_error();
    exp_t e;
    e.addr = 32'h500; e.be = 4'hF; e.wdata = 0; e.we = 0;
    e.stall_cyc = 3; e.vld = 0; e.fb = 1; e.ld = model_ld;
    sb.push_back(e);
    do_access(1, 0, 2'd2, 0, 32'h500, 32'h0, 0, 0, 32'h13579BDF, 1, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_fb !== e.fb) begin n_bad++; $display("FAIL err_fault got=%0d want=%0d", obs_fb, e.fb); end
    n_total++;
    if (obs_vld !== e.vld) begin n_bad++; $display("FAIL err_valid got=%0d want=%0d", obs_vld, e.vld); end
    n_total++;
    if (obs_ld !== e.ld) begin n_bad++; $display("FAIL err_ld got=%h want=%h", obs_ld, e.ld); end
    n_total++;
    if (obs_stall !== e.stall_cyc) begin n_bad++; $display("FAIL err_stall got=%0d want=%0d", obs_stall, e.stall_cyc); end
  endtask

  task automatic test_misaligned();
    exp_t e;
`ifdef LSU_ALIGN_CHECK_EN
    do_access(1, 0, 2'd2, 0, 32'h102, 32'h0, 0, 0, 32'h11223344, 0, 0);
    n_total++;
    if (obs_issued !== 1'b0) begin n_bad++; $display("FAIL mis_issued got=%b want=0", obs_issued); end
    n_total++;
    if (obs_stall !== 0) begin n_bad++; $display("FAIL mis_stall got=%0d want=0", obs_stall); end
    n_total++;
    if (obs_fm !== 1) begin n_bad++; $display("FAIL mis_fault got=%0d want=1", obs_fm); end
    n_total++;
    if (ld_data !== model_ld) begin n_bad++; $display("FAIL mis_ld got=%h want=%h", ld_data, model_ld); end
`else
    e.addr = 32'h100; e.be = 4'hF; e.wdata = 0; e.we = 0;
    e.stall_cyc = 3; e.vld = 1; e.fb = 0; e.ld = 32'h11223344;
    sb.push_back(e);
    e.be = 4'h8; e.ld = 32'h000000AB;
    sb.push_back(e);
    do_access(1, 0, 2'd2, 0, 32'h102, 32'h0, 0, 0, 32'h11223344, 0, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_addr !== e.addr || obs_be !== e.be || obs_ld !== e.ld || obs_fm !== 0) begin
      n_bad++; $display("FAIL mis_lw got=%h/%h/%h/%0d want=%h/%h/%h/0",
                        obs_addr, obs_be, obs_ld, obs_fm, e.addr, e.be, e.ld);
    end
    do_access(1, 0, 2'd1, 0, 32'h103, 32'h0, 0, 0, 32'hAB000000, 0, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_addr !== e.addr || obs_be !== e.be || obs_ld !== e.ld || obs_fm !== 0) begin
      n_bad++; $display("FAIL mis_lh got=%h/%h/%h/%0d want=%h/%h/%h/0",
                        obs_addr, obs_be, obs_ld, obs_fm, e.addr, e.be, e.ld);
    end
    model_ld = e.ld;
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.addr = 32'h600; e.be = 4'hF; e.wdata = 0; e.we = 0;
    e.stall_cyc = 3; e.vld = 1; e.fb = 0; e.ld = 32'h55AA33CC;
    sb.push_back(e);
    e.be = 4'h8; e.wdata = 32'hA5A5A5A5; e.we = 1; e.vld = 0;
    sb.push_back(e);
    do_access(1, 0, 2'd2, 0, 32'h600, 32'h0, 0, 0, 32'h55AA33CC, 0, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_ld !== e.ld || obs_vld !== e.vld || obs_stall !== e.stall_cyc) begin
      n_bad++; $display("FAIL b2b_first got=%h/%0d/%0d want=%h/%0d/%0d",
                        obs_ld, obs_vld, obs_stall, e.ld, e.vld, e.stall_cyc);
    end
    do_access(0, 1, 2'd0, 0, 32'h603, 32'h000000A5, 0, 0, 32'h0, 0, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_stall !== e.stall_cyc || obs_vld !== e.vld) begin
      n_bad++; $display("FAIL b2b_second_timing got=%0d/%0d want=%0d/%0d",
                        obs_stall, obs_vld, e.stall_cyc, e.vld);
    end
    n_total++;
    if (obs_be !== e.be || obs_wd !== e.wdata || obs_ld !== e.ld) begin
      n_bad++; $display("FAIL b2b_second_bus got=%h/%h/%h want=%h/%h/%h",
                        obs_be, obs_wd, obs_ld, e.be, e.wdata, e.ld);
    end
    model_ld = e.ld;
  endtask

  task automatic test_reset_mid();
    int c;
    int vseen;
    exp_t e;
    @(negedge clk);
    mem_re = 1; mem_we = 0; mem_size = 2'd2; mem_unsigned = 0; addr = 32'h700;
    c = 0;
    while (!dbus_req && c < 8) begin @(negedge clk); c++; end
    n_total++;
    if (!dbus_req) begin n_bad++; $display("FAIL rst_req_timeout got=0 want=1"); end
    dbus_gnt = 1;
    @(negedge clk);
    dbus_gnt = 0;
    #1 reset = 1; mem_re = 0;
    #1;
    n_total++;
    if ({stall, dbus_req, dbus_we, ld_valid, fault_bus} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid_flags got=%b want=00000", {stall, dbus_req, dbus_we, ld_valid, fault_bus});
    end
    n_total++;
    if (dbus_addr !== 32'h0 || dbus_be !== 4'h0 || ld_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_regs got=%h/%h/%h want=0/0/0", dbus_addr, dbus_be, ld_data);
    end
    @(negedge clk);
    reset = 0;
    dbus_rvalid = 1; dbus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dbus_rvalid = 0;
    vseen = 0;
    for (int k = 0; k < 3; k++) begin
      #1 if (ld_valid || stall || dbus_req) vseen++;
      @(negedge clk);
    end
    n_total++;
    if (vseen !== 0 || ld_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_late_rvalid got=%0d/%h want=0/0", vseen, ld_data);
    end
    model_ld = 32'h0;
    e.addr = 32'h704; e.be = 4'h8; e.wdata = 32'h3C3C3C3C; e.we = 1;
    e.stall_cyc = 3; e.vld = 0; e.fb = 0; e.ld = model_ld;
    sb.push_back(e);
    do_access(0, 1, 2'd0, 0, 32'h707, 32'h0000003C, 0, 0, 32'h0, 0, 1);
    e = sb.pop_front();
    n_total++;
    if (obs_addr !== e.addr || obs_be !== e.be || obs_wd !== e.wdata || obs_stall !== e.stall_cyc) begin
      n_bad++; $display("FAIL rst_after_sb got=%h/%h/%h/%0d want=%h/%h/%h/%0d",
                        obs_addr, obs_be, obs_wd, obs_stall, e.addr, e.be, e.wdata, e.stall_cyc);
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1;
    mem_re = 0; mem_we = 0; mem_size = 2'd0; mem_unsigned = 0; addr = 0; wdata = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0; dbus_err = 0;
    model_ld = 0;
    test_reset();
    test_loads();
    test_stores();
    test_bus_error();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
